line_buffer_5row: RTL

LINE_BUFFER_5ROW -- requirements
Module: line_buffer_5row

---
 rtl/line_buffer_5row_pkg.sv | 18 +
 rtl/row_bank.sv | 33 +++
 rtl/line_buffer_5row.sv | 103 ++++++++++
 3 files changed

// File: rtl/line_buffer_5row_pkg.sv
// rtl/line_buffer_5row_pkg.sv - shared row-count and vertical-tap rotation constants
package line_buffer_5row_pkg;

    localparam int NUM_ROWS = 5;
    localparam int BANK_BITS = 3;
    localparam logic [BANK_BITS-1:0] LAST_BANK = 3'd4;
    localparam logic [BANK_BITS-1:0] ROWS_FULL = 3'd4;

    function automatic logic [BANK_BITS-1:0] next_bank(input logic [BANK_BITS-1:0] bank);
        return (bank == LAST_BANK) ? 3'd0 : bank + 3'd1;
    endfunction

    // Rotation code for the 5-tap filter: the bank after the one being written holds the oldest row.
    function automatic logic [BANK_BITS-1:0] hsel_of(input logic [BANK_BITS-1:0] bank);
        return next_bank(bank);
    endfunction

endpackage

// File: rtl/row_bank.sv
// rtl/row_bank.sv - one line of pixel storage, simple dual-port RAM with synchronous read
module row_bank #(
    parameter int WIDTH     = 640,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [WIDTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; the array itself keeps its contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= 8'd0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer_5row.sv
// rtl/line_buffer_5row.sv - five-line buffer feeding a 5-tap vertical filter
module line_buffer_5row
    import line_buffer_5row_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int COL_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           din,
    input  logic                 validin,
    input  logic                 sof,
    output logic [7:0]           dout0,
    output logic [7:0]           dout1,
    output logic [7:0]           dout2,
    output logic [7:0]           dout3,
    output logic [7:0]           dout4,
    output logic [BANK_BITS-1:0] hsel,
    output logic                 validout
);

    localparam int ADDR_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);

    logic [COL_BITS-1:0]  col;
    logic [COL_BITS-1:0]  eff_col;
    logic [BANK_BITS-1:0] wbank;
    logic [BANK_BITS-1:0] eff_bank;
    logic [BANK_BITS-1:0] rows_done;
    logic [BANK_BITS-1:0] eff_rows;
    logic [BANK_BITS-1:0] beat_bank;
    logic [7:0]           din_q;
    logic [7:0]           rd_data [NUM_ROWS];
    logic [ADDR_BITS-1:0] addr;
    logic                 accept;

    assign accept = validin && !reset;

    // A qualified sof restarts the frame on this very beat.
    always_comb begin
        eff_col  = col;
        eff_bank = wbank;
        eff_rows = rows_done;
        if (sof) begin
            eff_col  = '0;
            eff_bank = '0;
            eff_rows = '0;
        end
        addr = eff_col[ADDR_BITS-1:0];
    end

    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_bank
        row_bank #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (ADDR_BITS)
        ) u_bank (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (accept && (eff_bank == 3'(k))),
            .wr_addr (addr),
            .wr_data (din),
            .rd_en   (accept),
            .rd_addr (addr),
            .rd_data (rd_data[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col       <= '0;
            wbank     <= '0;
            rows_done <= '0;
            beat_bank <= '0;
            din_q     <= 8'd0;
            hsel      <= '0;
            validout  <= 1'b0;
        end else if (validin) begin
            din_q     <= din;
            beat_bank <= eff_bank;
            hsel      <= hsel_of(eff_bank);
            validout  <= (eff_rows == ROWS_FULL);
            if (eff_col == LAST_COL) begin
                col       <= '0;
                wbank     <= next_bank(eff_bank);
                rows_done <= (eff_rows == ROWS_FULL) ? eff_rows : eff_rows + 3'd1;
            end else begin
                col       <= eff_col + COL_BITS'(1);
                wbank     <= eff_bank;
                rows_done <= eff_rows;
            end
        end else begin
            validout <= 1'b0;
        end
    end

    // The bank being written returns the registered input instead of its RAM read.
    assign dout0 = (beat_bank == 3'd0) ? din_q : rd_data[0];
    assign dout1 = (beat_bank == 3'd1) ? din_q : rd_data[1];
    assign dout2 = (beat_bank == 3'd2) ? din_q : rd_data[2];
    assign dout3 = (beat_bank == 3'd3) ? din_q : rd_data[3];
    assign dout4 = (beat_bank == 3'd4) ? din_q : rd_data[4];

endmodule
